decompression_arbiter: RTL and testbench

Receive-side counterpart of the compression arbiter. Parses the framed compressed stream (one 32-bit header beat per page, then the compressed body), dispatches each page body round-robin to `DECOMP_CORES` external decompression cores, and re-collects the decompressed pages in the original order onto a single AXI4-Stream output. It checks both header sizes against the actual byte counts and raises sticky error flags on any mismatch.

---
 rtl/decompression_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_decompression_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decompression_arbiter.sv
// Receive-side page arbiter: parses header+body frames, deals bodies round-robin
// to the decompression cores and re-serialises their output in header order.

module decompression_arbiter_lane (
  input  logic in_sel,
  input  logic out_sel,
  input  logic body_vld,
  input  logic rd_rdy,
  output logic core_tvalid,
  output logic core_rd_ready
);
  assign core_tvalid   = in_sel & body_vld;
  assign core_rd_ready = out_sel & rd_rdy;
endmodule

module decompression_arbiter #(
  parameter  int DECOMP_CORES  = 4,
  parameter  int AXI_DATA_BITS = 512,
  parameter  int SIZE_WIDTH    = 16,
  parameter  int EXP_DEPTH     = 8,
  localparam int KEEP_W        = AXI_DATA_BITS / 8
) (
  input  logic                                       aclk,
  input  logic                                       areset,
  input  logic [AXI_DATA_BITS-1:0]                   i_data_tdata,
  input  logic [KEEP_W-1:0]                          i_data_tkeep,
  input  logic                                       i_data_tlast,
  input  logic                                       i_data_tvalid,
  output logic                                       i_data_tready,
  output logic [DECOMP_CORES-1:0][AXI_DATA_BITS-1:0] o_core_tdata,
  output logic [DECOMP_CORES-1:0][KEEP_W-1:0]        o_core_tkeep,
  output logic [DECOMP_CORES-1:0]                    o_core_tlast,
  output logic [DECOMP_CORES-1:0]                    o_core_tvalid,
  input  logic [DECOMP_CORES-1:0]                    i_core_tready,
  input  logic [DECOMP_CORES-1:0][AXI_DATA_BITS-1:0] i_core_tdata,
  input  logic [DECOMP_CORES-1:0][KEEP_W-1:0]        i_core_tkeep,
  input  logic [DECOMP_CORES-1:0]                    i_core_tlast,
  input  logic [DECOMP_CORES-1:0]                    i_core_tvalid,
  output logic [DECOMP_CORES-1:0]                    o_core_rd_ready,
  output logic [AXI_DATA_BITS-1:0]                   o_data_tdata,
  output logic [KEEP_W-1:0]                          o_data_tkeep,
  output logic                                       o_data_tlast,
  output logic                                       o_data_tvalid,
  input  logic                                       o_data_tready,
  output logic                                       o_com_err,
  output logic                                       o_uncom_err,
  output logic                                       o_fmt_err
);
  localparam int PTR_W = (DECOMP_CORES > 1) ? $clog2(DECOMP_CORES) : 1;
  localparam int FP_W  = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;
  localparam int CNT_W = $clog2(EXP_DEPTH + 1);

  typedef enum logic {HEADER, BODY} state_t;
  state_t state, state_nxt;

  logic [PTR_W-1:0]      in_ptr, out_ptr;
  logic [SIZE_WIDTH-1:0] com_size, in_cnt, out_cnt, in_cnt_nxt, out_cnt_nxt, exp_head;
  logic [SIZE_WIDTH-1:0] exp_mem [EXP_DEPTH];
  logic [FP_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  fifo_full, fifo_empty, push, pop;
  logic                  hdr_hs, body_hs, body_vld, out_hs, rd_rdy;

  function automatic logic [SIZE_WIDTH-1:0] popcnt(input logic [KEEP_W-1:0] k);
    popcnt = '0;
    for (int i = 0; i < KEEP_W; i++) popcnt = popcnt + SIZE_WIDTH'(k[i]);
  endfunction

  assign fifo_full   = (fifo_cnt == CNT_W'(EXP_DEPTH));
  assign fifo_empty  = (fifo_cnt == '0);
  assign exp_head    = exp_mem[rd_ptr];
  assign in_cnt_nxt  = in_cnt + popcnt(i_data_tkeep);
  assign out_cnt_nxt = out_cnt + popcnt(o_data_tkeep);

  // input FSM: state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= HEADER;
    else        state <= state_nxt;
  end

  // input FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      HEADER: if (hdr_hs && !i_data_tlast) state_nxt = BODY;
      BODY:   if (body_hs && i_data_tlast) state_nxt = HEADER;
      default: state_nxt = HEADER;
    endcase
  end

  // input FSM: outputs; handshakes are held low through reset
  always_comb begin
    i_data_tready = 1'b0;
    body_vld      = 1'b0;
    if (!areset) begin
      case (state)
        HEADER: i_data_tready = !fifo_full;
        BODY: begin
          body_vld      = i_data_tvalid;
          i_data_tready = i_core_tready[in_ptr];
        end
        default: ;
      endcase
    end
    hdr_hs  = (state == HEADER) && i_data_tvalid && i_data_tready;
    body_hs = (state == BODY)   && i_data_tvalid && i_data_tready;
  end

  assign o_data_tdata  = i_core_tdata[out_ptr];
  assign o_data_tkeep  = i_core_tkeep[out_ptr];
  assign o_data_tlast  = i_core_tlast[out_ptr];
  assign o_data_tvalid = !areset && !fifo_empty && i_core_tvalid[out_ptr];
  assign rd_rdy        = !areset && !fifo_empty && o_data_tready;
  assign out_hs        = o_data_tvalid && o_data_tready;

  assign push = hdr_hs && !i_data_tlast;
  assign pop  = out_hs && o_data_tlast;

  for (genvar g = 0; g < DECOMP_CORES; g++) begin : g_lane
    assign o_core_tdata[g] = i_data_tdata;
    assign o_core_tkeep[g] = i_data_tkeep;
    assign o_core_tlast[g] = i_data_tlast;
    decompression_arbiter_lane u_lane (
      .in_sel        (in_ptr == PTR_W'(g)),
      .out_sel       (out_ptr == PTR_W'(g)),
      .body_vld      (body_vld),
      .rd_rdy        (rd_rdy),
      .core_tvalid   (o_core_tvalid[g]),
      .core_rd_ready (o_core_rd_ready[g])
    );
  end

  always_ff @(posedge aclk) begin
    if (push) exp_mem[wr_ptr] <= i_data_tdata[2*SIZE_WIDTH-1 -: SIZE_WIDTH];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == FP_W'(EXP_DEPTH-1)) ? '0 : wr_ptr + FP_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == FP_W'(EXP_DEPTH-1)) ? '0 : rd_ptr + FP_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // byte accounting on both sides; counts wrap at SIZE_WIDTH like the header fields
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      in_ptr      <= '0;
      out_ptr     <= '0;
      com_size    <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      o_com_err   <= 1'b0;
      o_uncom_err <= 1'b0;
      o_fmt_err   <= 1'b0;
    end else begin
      if (hdr_hs) begin
        if (i_data_tlast) o_fmt_err <= 1'b1;
        else begin
          com_size <= i_data_tdata[SIZE_WIDTH-1:0];
          in_cnt   <= '0;
        end
      end
      if (body_hs) begin
        in_cnt <= in_cnt_nxt;
        if (i_data_tlast) begin
          if (in_cnt_nxt != com_size) o_com_err <= 1'b1;
          in_ptr <= (in_ptr == PTR_W'(DECOMP_CORES-1)) ? '0 : in_ptr + PTR_W'(1);
        end
      end
      if (out_hs) begin
        if (o_data_tlast) begin
          if (out_cnt_nxt != exp_head) o_uncom_err <= 1'b1;
          out_cnt <= '0;
          out_ptr <= (out_ptr == PTR_W'(DECOMP_CORES-1)) ? '0 : out_ptr + PTR_W'(1);
        end else begin
          out_cnt <= out_cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_decompression_arbiter.sv
// Random page traffic against a queue-based model of routing, ordering and size checks.

module tb_decompression_arbiter;
  localparam int NC = 4, DW = 32, KW = 4, SW = 16, ED = 8, MAXP = 64;

  logic aclk = 1'b0, areset = 1'b1;
  logic [DW-1:0] in_tdata = '0;
  logic [KW-1:0] in_tkeep = '0;
  logic in_tlast = 1'b0, in_tvalid = 1'b0, in_tready;
  logic [NC-1:0][DW-1:0] oc_tdata;
  logic [NC-1:0][KW-1:0] oc_tkeep;
  logic [NC-1:0] oc_tlast, oc_tvalid, oc_rd_ready;
  logic [NC-1:0] ic_tready = '0;
  logic [NC-1:0][DW-1:0] ic_tdata = '0;
  logic [NC-1:0][KW-1:0] ic_tkeep = '0;
  logic [NC-1:0] ic_tlast = '0, ic_tvalid = '0;
  logic [DW-1:0] out_tdata;
  logic [KW-1:0] out_tkeep;
  logic out_tlast, out_tvalid, out_tready = 1'b0;
  logic com_err, uncom_err, fmt_err;

  decompression_arbiter #(.DECOMP_CORES(NC), .AXI_DATA_BITS(DW), .SIZE_WIDTH(SW), .EXP_DEPTH(ED)) dut (
    .aclk(aclk), .areset(areset),
    .i_data_tdata(in_tdata), .i_data_tkeep(in_tkeep), .i_data_tlast(in_tlast),
    .i_data_tvalid(in_tvalid), .i_data_tready(in_tready),
    .o_core_tdata(oc_tdata), .o_core_tkeep(oc_tkeep), .o_core_tlast(oc_tlast),
    .o_core_tvalid(oc_tvalid), .i_core_tready(ic_tready),
    .i_core_tdata(ic_tdata), .i_core_tkeep(ic_tkeep), .i_core_tlast(ic_tlast),
    .i_core_tvalid(ic_tvalid), .o_core_rd_ready(oc_rd_ready),
    .o_data_tdata(out_tdata), .o_data_tkeep(out_tkeep), .o_data_tlast(out_tlast),
    .o_data_tvalid(out_tvalid), .o_data_tready(out_tready),
    .o_com_err(com_err), .o_uncom_err(uncom_err), .o_fmt_err(fmt_err)
  );

  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // page descriptors: body/decompressed beat counts, last-beat keeps, header fields
  int cb[MAXP], ub[MAXP], hcom[MAXP], hunc[MAXP];
  logic [KW-1:0] ck[MAXP], uk[MAXP];
  bit cmis[MAXP], umis[MAXP];
  logic [KW-1:0] km[4] = '{4'h1, 4'h3, 4'h7, 4'hF};

  typedef struct {int core; logic [DW-1:0] d; logic [KW-1:0] k; logic l; int p;} body_t;
  typedef struct {logic [DW-1:0] d; logic [KW-1:0] k; logic l; int p;} out_t;
  body_t exp_body[$];
  out_t  exp_out[$];
  int    core_q[NC][$];

  int in_core = 0;
  bit com_m = 0, unc_m = 0, fmt_m = 0;
  bit hold_out = 0, mon_en = 0, full_mode = 0;
  int first_pop_cyc = -1, last_acc_cyc = 0;

  function automatic logic [DW-1:0] bword(input int p, input int b);
    return {8'hB0, p[7:0], b[7:0], 8'h5A};
  endfunction
  function automatic logic [DW-1:0] uword(input int p, input int b);
    return {8'hD0, p[7:0], b[15:0]};
  endfunction

  // mode: 0 exact sizes, 1 random mismatches, 2 force com mismatch, 3 force uncom mismatch
  task automatic gen_page(input int p, input int mode, input int min_cb);
    int ac, au;
    cb[p] = $urandom_range(min_cb, 5);
    ub[p] = $urandom_range(1, 8);
    ck[p] = km[$urandom % 4];
    uk[p] = km[$urandom % 4];
    ac = (cb[p] - 1) * KW + $countones(ck[p]);
    au = (ub[p] - 1) * KW + $countones(uk[p]);
    cmis[p] = (mode == 2) || (mode == 1 && $urandom % 5 == 0);
    umis[p] = (mode == 3) || (mode == 1 && $urandom % 5 == 0);
    hcom[p] = cmis[p] ? ac + int'($urandom_range(1, 3)) : ac;
    hunc[p] = umis[p] ? au + int'($urandom_range(1, 3)) : au;
  endtask

  function automatic logic [DW-1:0] hdr_word(input int p);
    logic [15:0] u, c;
    u = hunc[p][15:0];
    c = hcom[p][15:0];
    return {u, c};
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    bit ok;
    int n;
    ok = 0; n = 0;
    in_tdata = d; in_tkeep = k; in_tlast = l; in_tvalid = 1'b1;
    while (!ok && n < 3000) begin
      @(negedge aclk);
      ok = in_tready;
      if (ok) last_acc_cyc = cyc;
      @(posedge aclk); #1;
      n++;
    end
    in_tvalid = 1'b0;
    if (!ok) chk("in_timeout", 0, 1);
  endtask

  task automatic gap();
    if ($urandom % 4 == 0) begin @(posedge aclk); #1; end
  endtask

  // queue the expected downstream traffic of page p before its header goes out
  task automatic prep_page(input int p);
    for (int b = 0; b < ub[p]; b++)
      exp_out.push_back('{uword(p, b), (b == ub[p]-1) ? uk[p] : {KW{1'b1}}, b == ub[p]-1, p});
    for (int b = 0; b < cb[p]; b++)
      exp_body.push_back('{in_core, bword(p, b), (b == cb[p]-1) ? ck[p] : {KW{1'b1}}, b == cb[p]-1, p});
  endtask

  task automatic send_hdr(input int p, input bit bad);
    if (bad) begin
      send_beat($urandom, 4'hF, 1'b1);
      fmt_m = 1;
    end
    prep_page(p);
    send_beat(hdr_word(p), 4'hF, 1'b0);
  endtask

  task automatic send_body(input int p, input int nmax);
    for (int b = 0; b < cb[p] && b < nmax; b++) begin
      gap();
      send_beat(bword(p, b), (b == cb[p]-1) ? ck[p] : {KW{1'b1}}, b == cb[p]-1);
    end
    if (nmax >= cb[p]) in_core = (in_core + 1) % NC;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_out.size() != 0 && n < 5000) begin @(posedge aclk); #1; n++; end
    chk("drain", exp_out.size(), 0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  // behavioural core: after a random latency, replays page p's decompressed beats
  task automatic core_src(input int k);
    int p;
    bit ok;
    forever begin
      @(posedge aclk); #1;
      if (core_q[k].size() != 0) begin
        p = core_q[k][0];
        repeat ($urandom_range(0, 8)) @(posedge aclk);
        #1;
        for (int b = 0; b < ub[p]; b++) begin
          ic_tdata[k]  = uword(p, b);
          ic_tkeep[k]  = (b == ub[p]-1) ? uk[p] : {KW{1'b1}};
          ic_tlast[k]  = (b == ub[p]-1);
          ic_tvalid[k] = 1'b1;
          ok = 0;
          while (!ok) begin
            @(negedge aclk); ok = oc_rd_ready[k];
            @(posedge aclk); #1;
          end
        end
        ic_tvalid[k] = 1'b0;
        void'(core_q[k].pop_front());
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge aclk); #1;
      out_tready = hold_out ? 1'b0 : ($urandom % 4 != 0);
      ic_tready  = NC'($urandom | $urandom);
    end
  end

  // monitor: flags first (model updates land next cycle), then body routing, then output order
  logic [DW+KW:0] prev_out;
  bit stall_prev = 0;
  always @(negedge aclk) begin
    if (mon_en) begin
      body_t e;
      out_t  o;
      chk("com_err", com_err, com_m);
      chk("uncom_err", uncom_err, unc_m);
      chk("fmt_err", fmt_err, fmt_m);
      if (oc_tvalid != '0) begin
        if (exp_body.size() == 0) chk("stray_core_valid", oc_tvalid, 0);
        else begin
          e = exp_body[0];
          chk("route", oc_tvalid, 64'(1) << e.core);
          chk("body_beat", {oc_tdata[e.core], oc_tkeep[e.core], oc_tlast[e.core]}, {e.d, e.k, e.l});
          if (ic_tready[e.core]) begin
            void'(exp_body.pop_front());
            if (e.l) begin
              core_q[e.core].push_back(e.p);
              if (cmis[e.p]) com_m = 1;
            end
          end
        end
      end
      if (stall_prev && !areset) chk("out_hold", {out_tvalid, out_tdata, out_tkeep, out_tlast}, {1'b1, prev_out});
      stall_prev = !areset && out_tvalid && !out_tready;
      prev_out   = {out_tdata, out_tkeep, out_tlast};
      if (out_tvalid && out_tready) begin
        if (exp_out.size() == 0) chk("stray_out", 1, 0);
        else begin
          o = exp_out.pop_front();
          chk("out_beat", {out_tdata, out_tkeep, out_tlast}, {o.d, o.k, o.l});
          if (o.l) begin
            if (umis[o.p]) unc_m = 1;
            if (full_mode && first_pop_cyc < 0) first_pop_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge aclk);
    $display("FAIL watchdog: got no finish expected finish within budget");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_tready"}, in_tready, 0);
    chk({tag, "_core_valid"}, oc_tvalid, 0);
    chk({tag, "_rd_ready"}, oc_rd_ready, 0);
    chk({tag, "_out_valid"}, out_tvalid, 0);
    chk({tag, "_flags"}, {com_err, uncom_err, fmt_err}, 0);
  endtask

  initial begin
    fork
      core_src(0); core_src(1); core_src(2); core_src(3);
    join_none
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_reset_outputs("rst");
    @(posedge aclk); #1;
    areset = 1'b0;
    mon_en = 1;
    @(negedge aclk);
    chk("idle_tready", in_tready, 1);
    @(posedge aclk); #1;

    // single clean page, then mixed traffic with size and format errors
    gen_page(0, 0, 1);
    cb[0] = 8; ck[0] = 4'hF; ub[0] = 16; uk[0] = 4'hF; hcom[0] = 32; hunc[0] = 64;
    send_hdr(0, 0);
    send_body(0, 99);
    for (int p = 1; p < 20; p++) begin
      gen_page(p, (p == 9) ? 2 : (p == 10) ? 3 : (p >= 4) ? 1 : 0, 1);
      send_hdr(p, (p == 7) || (p > 4 && $urandom % 6 == 0));
      send_body(p, 99);
    end
    drain();
    chk("flags_after_errors", {com_err, uncom_err, fmt_err}, 3'b111);

    // fill the expected-size FIFO with the output stalled
    hold_out = 1;
    @(posedge aclk); #1;
    for (int p = 20; p < 28; p++) begin
      gen_page(p, 0, 1);
      send_hdr(p, 0);
      send_body(p, 99);
    end
    gen_page(28, 0, 1);
    prep_page(28);
    in_tdata = hdr_word(28); in_tkeep = 4'hF; in_tlast = 1'b0; in_tvalid = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      chk("fifo_full_rdy", in_tready, 0);
      @(posedge aclk); #1;
    end
    full_mode = 1;
    first_pop_cyc = -1;
    hold_out = 0;
    send_beat(hdr_word(28), 4'hF, 1'b0);
    chk("full_release", 64'(last_acc_cyc - first_pop_cyc), 1);
    full_mode = 0;
    send_body(28, 99);
    drain();

    // reset in the middle of a page body
    gen_page(29, 0, 3);
    send_hdr(29, 0);
    send_body(29, 99);
    drain();
    gen_page(30, 0, 3);
    send_hdr(30, 0);
    send_body(30, 1);
    areset = 1'b1;
    exp_out.delete();
    exp_body.delete();
    for (int k = 0; k < NC; k++) core_q[k].delete();
    in_core = 0; com_m = 0; unc_m = 0; fmt_m = 0;
    @(negedge aclk);
    chk_reset_outputs("midrst");
    @(posedge aclk); #1;
    areset = 1'b0;
    gen_page(31, 0, 1);
    send_hdr(31, 0);
    send_body(31, 99);
    gen_page(32, 0, 1);
    send_hdr(32, 0);
    send_body(32, 99);
    drain();
    chk("flags_after_reset", {com_err, uncom_err, fmt_err}, 3'b000);

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
